dmem_axi_bridge: RTL and testbench
==================================

DMEM_AXI_BRIDGE -- requirements
Module: dmem_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_ce  in  1  MEM-stage access request, level.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_sel  in  4  CPU byte lanes; sel[3]=bits 31:24=address offset 0.
REQ-009 SHALL have port req_wdata  in  32  store data in CPU lane order.
REQ-010 SHALL have port rdata_o  out  32  load data in CPU lane order, held until the next load completes.
REQ-011 SHALL have port stall_o  out  1  pipeline stall while an access is outstanding.
REQ-012 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-013 SHALL have port bus_err_o  out  1  pulses with done_o when the response code is not OKAY.
REQ-014 SHALL have AXI4-Lite master ports: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, standard widths.

Function
REQ-015 SHALL use states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-016 In IDLE, SHALL accept a request when req_ce=1: req_we=0 -> RD_ADDR; req_we=1 -> WR_REQ.
REQ-017 On acceptance, SHALL latch addr, sel and wdata; later input changes SHALL have no effect.
REQ-018 SHALL drive araddr/awaddr as {req_addr[31:2],2'b00}.
REQ-019 SHALL byte-swap on the AXI side, so AXI lane k holds address offset k.
- wdata = {d[7:0],d[15:8],d[23:16],d[31:24]}
- wstrb[k] = sel[3-k]
- rdata_o = byte-swap of rdata
REQ-020 RD_ADDR: SHALL hold arvalid=1 until arready, then go to RD_DATA; rready=1 only in RD_DATA.
REQ-021 RD_DATA: on rvalid, SHALL register rdata_o and pulse done_o, then return to IDLE.
REQ-022 WR_REQ: SHALL assert awvalid and wvalid together and drop each independently on its ready, tracked with aw_done/w_done flags.
REQ-023 WR_REQ: when both channels have completed, SHALL go to WR_RESP; completion may be the same cycle or different cycles.
REQ-024 WR_RESP: bready=1; on bvalid, SHALL pulse done_o and return to IDLE.
REQ-025 SHALL give bus_err_o = (resp != 2'b00) in the done cycle, else 0.
REQ-026 SHALL compute stall_o = req_ce && !done_o combinationally; done_o is registered.
- stall_o=1 in the acceptance cycle and while busy.
- stall_o=0 in the done cycle.
REQ-027 The cycle after done_o, SHALL treat req_ce=1 as a new request.
- Minimum read latency: 3 cycles from acceptance to done, with zero-wait AXI.
- Back-to-back accesses take one IDLE cycle between them.
REQ-028 Outside their states, valid and ready outputs SHALL be 0.
REQ-029 A store with req_sel=4'b0000 SHALL still run the full write transaction with wstrb=0.
REQ-030 SHALL have no internal abort; the request path gates exceptions before req_ce.

Reset
REQ-031 When rst=1, SHALL go to IDLE and clear all outputs to 0.
- Covers rdata_o, done_o, bus_err_o, all valids and readies, aw_done and w_done.
REQ-032 Reset mid-transaction SHALL abandon the access with no done_o; the interconnect is reset with the core.

Structure
REQ-033 A shared package SHALL hold: the state enum, AXI_RESP_OKAY=2'b00, and the byte-swap and lane-reverse functions (the data cache reuses them).
REQ-034 SHALL be a single module with no sub-module; the FSM plus its registers fit in one file.

Verification
REQ-035 The bench SHALL cover these scenarios:
- Load word: addr 0x1000_0004, sel 1111, memory bytes 11 22 33 44 at offsets 0..3 -> araddr 0x1000_0004, rdata_o 0x11223344, done_o on cycle 3, stall_o 1 for cycles 0-2.
- Store byte: addr 0x0000_0013, sel 0001, wdata 0xAAAAAAAA -> awaddr 0x10, wstrb 1000, wdata 0xAAAAAAAA, done after bvalid.
- Split write handshake: awready 2 cycles before wready -> awvalid drops first, wvalid held, one bready phase, exactly one done_o.
- Error: rresp=2'b10 on a load -> bus_err_o=1 and done_o=1 in the same cycle, state IDLE next cycle.
- Reset while in RD_DATA with rvalid stalled -> all outputs 0 next cycle, no done_o, a new request is accepted afterwards.
- Back-to-back load then store, with req_ce held -> two separate AXI transactions, exactly two done_o pulses, stall_o low only in the done cycles.

Source files
------------

// File: rtl/dmem_axi_bridge_pkg.sv
// Shared types and lane helpers for the data-memory AXI4-Lite bridge.
// The lane helpers are also used by the data cache.
package dmem_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // CPU lane order puts address offset 0 in bits 31:24; AXI puts it in bits 7:0.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [3:0] lane_rev4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// MEM-stage load/store to AXI4-Lite master bridge.
// One access outstanding at a time; the pipeline is stalled until done_o.
module dmem_axi_bridge
    import dmem_axi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ce,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_sel,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              done_q, done_d;
    logic              bus_err_q, bus_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle still sees the old req_ce, so it must not re-accept.
                if (req_ce && !done_q) begin
                    addr_d    = req_addr & ~ADDR_W'(3);
                    sel_d     = req_sel;
                    wdata_d   = req_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    rdata_d   = bswap32(rdata);
                    done_d    = 1'b1;
                    bus_err_d = (rresp != AXI_RESP_OKAY);
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                if (awready && !aw_done_q) aw_done_d = 1'b1;
                if (wready && !w_done_q)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    done_d    = 1'b1;
                    bus_err_d = (bresp != AXI_RESP_OKAY);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        araddr    = addr_q;
        awaddr    = addr_q;
        wdata     = bswap32(wdata_q);
        wstrb     = lane_rev4(sel_q);
        arvalid   = (state_q == RD_ADDR);
        rready    = (state_q == RD_DATA);
        awvalid   = (state_q == WR_REQ) && !aw_done_q;
        wvalid    = (state_q == WR_REQ) && !w_done_q;
        bready    = (state_q == WR_RESP);
        rdata_o   = rdata_q;
        done_o    = done_q;
        bus_err_o = bus_err_q;
        stall_o   = req_ce && !done_q;
    end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Randomized bench for dmem_axi_bridge: a scheduled AXI slave with a byte memory
// and per-cycle expectations derived from the handshake timing rules.
module tb_dmem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ce, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic [31:0] rdata_o;
    logic        stall_o, done_o, bus_err_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem [256];
    logic [31:0] held_rd;

    always #5 clk = ~clk;

    dmem_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr),
        .req_sel(req_sel), .req_wdata(req_wdata),
        .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o), .bus_err_o(bus_err_o),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic quiet_checks(input string tag);
        check({tag, " done"},    32'(done_o),    32'd0);
        check({tag, " berr"},    32'(bus_err_o), 32'd0);
        check({tag, " stall"},   32'(stall_o),   32'(req_ce));
        check({tag, " rdata_o"}, rdata_o,        held_rd);
        check({tag, " valids"},  32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    endtask

    // One access: waits a cycle, idles for gap cycles, then presents the request
    // (cycle 0) and checks every cycle through the done cycle, where it returns.
    task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input int unsigned da, input int unsigned db,
                          input int unsigned dc, input logic [1:0] resp, input int unsigned gap);
        logic [31:0] wa, exp_wd, axi_rd, cpu_rd;
        logic [3:0]  exp_strb;
        int unsigned i0, m, done_at;
        string       tg;
        wa = {addr[31:2], 2'b00};
        i0 = int'(wa[7:0]);
        m  = (da > db) ? da : db;
        for (int k = 0; k < 4; k++) begin
            exp_wd[8*k +: 8] = wd[8*(3-k) +: 8];
            exp_strb[k]      = sel[3-k];
            axi_rd[8*k +: 8] = mem[i0 + k];
            cpu_rd[8*(3-k) +: 8] = mem[i0 + k];
        end
        done_at = we ? (3 + m + dc) : (3 + da + db);
        tg = we ? "wr" : "rd";

        @(posedge clk); @(negedge clk);
        slave_idle();
        for (int unsigned g = 0; g < gap; g++) begin
            req_ce = 1'b0;
            #1 quiet_checks("gap");
            @(posedge clk); @(negedge clk);
        end
        req_ce = 1'b1; req_we = we; req_addr = addr; req_sel = sel; req_wdata = wd;

        for (int unsigned c = 0; c <= done_at; c++) begin
            if (c > 0) begin
                @(posedge clk); @(negedge clk);
                req_we = 1'($urandom); req_addr = $urandom;
                req_sel = 4'($urandom); req_wdata = $urandom;
            end
            slave_idle();
            if (we) begin
                awready = (c == 1 + da);
                wready  = (c == 1 + db);
                bvalid  = (c == 2 + m + dc);
                bresp   = resp;
            end else begin
                arready = (c == 1 + da);
                rvalid  = (c == 2 + da + db);
                rdata   = axi_rd;
                rresp   = resp;
            end
            #1;
            if (c == done_at && !we) held_rd = cpu_rd;
            check({tg, " done"},    32'(done_o),    32'(c == done_at));
            check({tg, " stall"},   32'(stall_o),   32'(c != done_at));
            check({tg, " berr"},    32'(bus_err_o), 32'(c == done_at && resp != 2'b00));
            check({tg, " rdata_o"}, rdata_o,        held_rd);
            if (we) begin
                check("wr awvalid", 32'(awvalid), 32'(c >= 1 && c <= 1 + da));
                check("wr wvalid",  32'(wvalid),  32'(c >= 1 && c <= 1 + db));
                check("wr bready",  32'(bready),  32'(c >= 2 + m && c <= 2 + m + dc));
                check("wr rd-chan", 32'({arvalid, rready}), 32'd0);
                if (awvalid) check("wr awaddr", awaddr, wa);
                if (wvalid) begin
                    check("wr wdata", wdata, exp_wd);
                    check("wr wstrb", 32'(wstrb), 32'(exp_strb));
                end
            end else begin
                check("rd arvalid", 32'(arvalid), 32'(c >= 1 && c <= 1 + da));
                check("rd rready",  32'(rready),  32'(c >= 2 + da && c <= 2 + da + db));
                check("rd wr-chan", 32'({awvalid, wvalid, bready}), 32'd0);
                if (arvalid) check("rd araddr", araddr, wa);
            end
        end
        if (we && resp == 2'b00)
            for (int k = 0; k < 4; k++)
                if (sel[3-k]) mem[i0 + k] = wd[8*(3-k) +: 8];
    endtask

    initial begin
        logic [1:0] rr;
        rst = 1'b1; req_ce = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0; req_wdata = '0;
        rdata = '0; rresp = '0; bresp = '0; held_rd = '0;
        slave_idle();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;

        repeat (3) @(negedge clk);
        #1 quiet_checks("reset");
        rst = 1'b0;

        access(1'b0, 32'h1000_0004, 4'b1111, 32'h0, 0, 0, 0, 2'b00, 1);
        check("load word value", rdata_o, 32'h1122_3344);
        access(1'b1, 32'h0000_0013, 4'b0001, 32'hAAAA_AAAA, 0, 0, 1, 2'b00, 1);
        access(1'b1, 32'h0000_0020, 4'b1100, 32'h1234_5678, 0, 2, 0, 2'b00, 2);
        access(1'b1, 32'h0000_0024, 4'b0000, 32'hDEAD_BEEF, 1, 1, 0, 2'b00, 1);
        access(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 0, 1, 0, 2'b10, 1);
        @(posedge clk); @(negedge clk);
        req_ce = 1'b0;
        #1 quiet_checks("post-err idle");

        // Reset while RD_DATA waits on rvalid.
        @(posedge clk); @(negedge clk);
        req_ce = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0030; req_sel = 4'hF;
        @(posedge clk); @(negedge clk); arready = 1'b1;
        @(posedge clk); @(negedge clk); arready = 1'b0;
        #1 check("rst pre rready", 32'(rready), 32'd1);
        @(posedge clk); @(negedge clk);
        rst = 1'b1; req_ce = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b00;
        held_rd = '0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            #1 quiet_checks("mid-rst");
        end
        rst = 1'b0; rvalid = 1'b0;
        access(1'b0, 32'h1000_0004, 4'b1111, 32'h0, 1, 0, 0, 2'b00, 1);

        // Back-to-back load then store with req_ce held high.
        access(1'b0, 32'h0000_0080, 4'b1111, 32'h0, 0, 0, 0, 2'b00, 1);
        access(1'b1, 32'h0000_0084, 4'b0110, 32'hCAFE_F00D, 0, 0, 0, 2'b00, 0);
        access(1'b0, 32'h0000_0084, 4'b1111, 32'h0, 0, 0, 0, 2'b00, 0);

        for (int n = 0; n < 60; n++) begin
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            access(1'($urandom), $urandom, 4'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   rr, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
